// File: rtl/ahb_lite_master_port_if.sv
// Command/response stream plus AHB-Lite bus signals of the single-initiator master port.
// The master modport is the port block's view; slave is the sequencer/interconnect side.
interface ahb_lite_master_port_if #(
  parameter int unsigned AW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [1:0]    cmd_size;
  logic [31:0]   cmd_wdata;

  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_master_port.sv
// AHB-Lite single-initiator master: valid/ready commands become pipelined NONSEQ/SINGLE
// transfers, with one registered response per command (including cancelled follow-ons).
module ahb_lite_master_port #(
  parameter int unsigned AW        = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input logic                    HCLK,
  input logic                    HRESET,
  ahb_lite_master_port_if.master bus
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  logic          ap_valid;
  logic [AW-1:0] ap_addr;
  logic          ap_write;
  logic [1:0]    ap_size;
  logic [31:0]   ap_wdata;

  logic          dp_valid;
  logic          dp_write;
  logic [1:0]    dp_size;
  logic [1:0]    dp_addr_lo;
  logic [31:0]   hwdata_q;

  logic          cancel_pend;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic          err_first;
  logic          cmd_ready_c;
  logic          accept;
  logic [1:0]    cmd_size_n;
  logic [AW-1:0] cmd_addr_n;
  logic [31:0]   wdata_rep;
  logic [31:0]   rdata_ext;
  htrans_e       htrans;

  always_comb begin
    cmd_size_n = (bus.cmd_size == 2'd3) ? 2'd2 : bus.cmd_size;
    cmd_addr_n = bus.cmd_addr;
    if (cmd_size_n == 2'd1)      cmd_addr_n[0]   = 1'b0;
    else if (cmd_size_n == 2'd2) cmd_addr_n[1:0] = '0;
  end

  always_comb begin
    err_first   = dp_valid & bus.HRESP & ~bus.HREADY;
    cmd_ready_c = (~ap_valid | bus.HREADY) & ~err_first & ~cancel_pend;
    accept      = bus.cmd_valid & cmd_ready_c;
  end

  always_comb begin
    case (ap_size)
      2'd0:    wdata_rep = {4{ap_wdata[7:0]}};
      2'd1:    wdata_rep = {2{ap_wdata[15:0]}};
      default: wdata_rep = ap_wdata;
    endcase
  end

  always_comb begin
    rdata_ext = '0;
    if (!dp_write) begin
      case (dp_size)
        2'd0:    rdata_ext = (bus.HRDATA >> {dp_addr_lo, 3'b000}) & 32'h0000_00FF;
        2'd1:    rdata_ext = (bus.HRDATA >> {dp_addr_lo[1], 4'b0000}) & 32'h0000_FFFF;
        default: rdata_ext = bus.HRDATA;
      endcase
    end
  end

  // Address phase may also fill during a wait state when empty; an ERROR first cycle
  // squashes whatever sits in the address phase so HTRANS is IDLE in the second cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_valid   <= 1'b0;
      ap_addr    <= '0;
      ap_write   <= 1'b0;
      ap_size    <= '0;
      ap_wdata   <= '0;
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      dp_size    <= '0;
      dp_addr_lo <= '0;
      hwdata_q   <= '0;
    end else if (bus.HREADY) begin
      dp_valid   <= ap_valid;
      dp_write   <= ap_write;
      dp_size    <= ap_size;
      dp_addr_lo <= ap_addr[1:0];
      hwdata_q   <= wdata_rep;
      ap_valid   <= accept;
      if (accept) begin
        ap_addr  <= cmd_addr_n;
        ap_write <= bus.cmd_write;
        ap_size  <= cmd_size_n;
        ap_wdata <= bus.cmd_wdata;
      end
    end else if (err_first && ap_valid) begin
      ap_valid <= 1'b0;
    end else if (accept) begin
      ap_valid <= 1'b1;
      ap_addr  <= cmd_addr_n;
      ap_write <= bus.cmd_write;
      ap_size  <= cmd_size_n;
      ap_wdata <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cancel_pend <= 1'b0;
    end else begin
      if (dp_valid && bus.HREADY) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= bus.HRESP;
        rsp_rdata_q <= rdata_ext;
      end else if (cancel_pend) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
        cancel_pend <= 1'b0;
      end else begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end
      if (!bus.HREADY && err_first && ap_valid) cancel_pend <= 1'b1;
    end
  end

  always_comb begin
    htrans        = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.cmd_ready = cmd_ready_c;
    bus.HTRANS    = htrans;
    bus.HADDR     = ap_addr;
    bus.HWRITE    = ap_write;
    bus.HSIZE     = {1'b0, ap_size};
    bus.HBURST    = 3'b000;
    bus.HPROT     = HPROT_VAL;
    bus.HWDATA    = hwdata_q;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_err   = rsp_err_q;
    bus.rsp_rdata = rsp_rdata_q;
  end

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Bench for ahb_lite_master_port: transaction-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with a random slave.
module tb_ahb_lite_master_port;

  typedef struct {
    logic [31:0] addr;
    bit          write;
    int unsigned sz;
    logic [31:0] wdata;
  } cmd_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_port_if #(.AW(32)) bus ();

  ahb_lite_master_port #(.AW(32), .HPROT_VAL(4'b0011)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_seen = 0;

  // Reference model: transfers waiting in address phase, in data phase, and cancelled ones.
  cmd_t        aq[$];
  cmd_t        dq[$];
  cmd_t        cq[$];
  bit          m_took;
  bit          m_rsp_v;
  bit          m_rsp_err;
  logic [31:0] m_rsp_d;
  logic [31:0] m_hw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t normalize(input logic [31:0] a, input bit w, input logic [1:0] s,
                                     input logic [31:0] d);
    cmd_t c;
    c.sz    = (s == 2'd3) ? 2 : int'(s);
    c.addr  = a & ~(32'((1 << c.sz) - 1));
    c.write = w;
    c.wdata = d;
    return c;
  endfunction

  function automatic logic [31:0] replicate(input cmd_t c);
    if (c.sz == 0) return 32'(c.wdata[7:0]) * 32'h0101_0101;
    if (c.sz == 1) return 32'(c.wdata[15:0]) * 32'h0001_0001;
    return c.wdata;
  endfunction

  function automatic logic [31:0] extract(input cmd_t c, input logic [31:0] d);
    int unsigned off;
    off = 8 * (c.addr % 4);
    if (c.sz == 0) return (d >> off) % 256;
    if (c.sz == 1) return (d >> off) % 65536;
    return d;
  endfunction

  function automatic bit model_ready();
    bit stall;
    stall = (dq.size() != 0) && bus.HRESP && !bus.HREADY;
    return (aq.size() == 0 || bus.HREADY) && !stall && (cq.size() == 0);
  endfunction

  always @(posedge HCLK or posedge HRESET) begin
    cmd_t c;
    bit   take;
    if (HRESET) begin
      aq.delete(); dq.delete(); cq.delete();
      m_took = 0; m_rsp_v = 0; m_rsp_err = 0; m_rsp_d = '0; m_hw = '0;
    end else begin
      take = bus.cmd_valid && model_ready();
      m_took = take;
      m_rsp_v = 0; m_rsp_err = 0; m_rsp_d = '0;
      if (dq.size() != 0 && bus.HREADY) begin
        c = dq.pop_front();
        m_rsp_v = 1; m_rsp_err = bus.HRESP;
        m_rsp_d = c.write ? 32'h0 : extract(c, bus.HRDATA);
      end else if (cq.size() != 0) begin
        c = cq.pop_front();
        m_rsp_v = 1; m_rsp_err = 1; m_rsp_d = '0;
      end
      if (bus.HREADY) begin
        if (aq.size() != 0) begin
          c = aq.pop_front();
          m_hw = replicate(c);
          dq.push_back(c);
        end
        if (take) aq.push_back(normalize(bus.cmd_addr, bus.cmd_write, bus.cmd_size, bus.cmd_wdata));
      end else if (dq.size() != 0 && bus.HRESP && aq.size() != 0) begin
        cq.push_back(aq.pop_front());
      end else if (take) begin
        aq.push_back(normalize(bus.cmd_addr, bus.cmd_write, bus.cmd_size, bus.cmd_wdata));
      end
    end
  end

  // Registered outputs checked at the negedge; cmd_ready once this cycle's inputs have settled.
  always @(negedge HCLK) begin
    check("htrans", 32'(bus.HTRANS), (aq.size() != 0) ? 32'h2 : 32'h0);
    if (aq.size() != 0) begin
      check("haddr", bus.HADDR, aq[0].addr);
      check("hwrite", 32'(bus.HWRITE), 32'(aq[0].write));
      check("hsize", 32'(bus.HSIZE), aq[0].sz);
    end
    check("hburst", 32'(bus.HBURST), 32'h0);
    check("hprot", 32'(bus.HPROT), 32'h3);
    if (dq.size() != 0 && dq[0].write) check("hwdata", bus.HWDATA, m_hw);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_v));
    if (m_rsp_v) begin
      check("rsp_err", 32'(bus.rsp_err), 32'(m_rsp_err));
      check("rsp_rdata", bus.rsp_rdata, m_rsp_d);
    end
    if (bus.rsp_valid === 1'b1) rsp_seen++;
    #3;
    check("cmd_ready", 32'(bus.cmd_ready), 32'(model_ready()));
  end

  task automatic drive(input bit cv, input logic [31:0] a, input bit w, input logic [1:0] s,
                       input logic [31:0] wd, input bit rdy, input bit resp, input logic [31:0] rd);
    @(negedge HCLK);
    #1;
    bus.cmd_valid = cv; bus.cmd_addr = a; bus.cmd_write = w; bus.cmd_size = s;
    bus.cmd_wdata = wd; bus.HREADY = rdy; bus.HRESP = resp; bus.HRDATA = rd;
    #1;
  endtask

  task automatic idle(input logic [31:0] rd);
    drive(1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, rd);
  endtask

  initial begin
    int          r0;
    int          lowcnt;
    bit          pending;
    int unsigned err_stage;
    int unsigned r;
    logic [31:0] wr_addr [4];

    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_write = 0; bus.cmd_size = '0;
    bus.cmd_wdata = '0; bus.HREADY = 1; bus.HRESP = 0; bus.HRDATA = '0;
    repeat (3) @(negedge HCLK);
    #2 HRESET = 1'b0;
    idle(32'h0);
    check("reset_htrans", 32'(bus.HTRANS), 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_ready", 32'(bus.cmd_ready), 32'h1);

    // Word read, zero wait.
    drive(1'b1, 32'h4000_0000, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("rd_accept_ready", 32'(bus.cmd_ready), 32'h1);
    idle(32'hDEAD_BEEF);
    check("rd_nonseq", 32'(bus.HTRANS), 32'h2);
    check("rd_hsize", 32'(bus.HSIZE), 32'h2);
    check("rd_haddr", bus.HADDR, 32'h4000_0000);
    idle(32'hDEAD_BEEF);
    check("rd_dphase_idle", 32'(bus.HTRANS), 32'h0);
    idle(32'hDEAD_BEEF);
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err", 32'(bus.rsp_err), 32'h0);

    // Byte write with lane replication.
    drive(1'b1, 32'h4000_0003, 1'b1, 2'd0, 32'h0000_00A5, 1'b1, 1'b0, 32'h0);
    idle(32'h0);
    check("bw_haddr", bus.HADDR, 32'h4000_0003);
    check("bw_hsize", 32'(bus.HSIZE), 32'h0);
    idle(32'h0);
    check("bw_hwdata", bus.HWDATA, 32'hA5A5_A5A5);
    idle(32'h0);
    check("bw_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("bw_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("bw_rsp_err", 32'(bus.rsp_err), 32'h0);

    // Half read from upper half-word.
    drive(1'b1, 32'h4000_0002, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0, 32'h1234_ABCD);
    idle(32'h1234_ABCD);
    idle(32'h1234_ABCD);
    idle(32'h1234_ABCD);
    check("hr_rsp_rdata", bus.rsp_rdata, 32'h0000_1234);

    // Four back-to-back writes, two wait states on the second.
    wr_addr = '{32'h4000_0010, 32'h4000_0014, 32'h4000_0018, 32'h4000_001C};
    r0 = rsp_seen; lowcnt = 0;
    for (int i = 0; i < 10; i++) begin
      int k;
      k = (i < 3) ? i : 3;
      drive(i < 6, wr_addr[k], 1'b1, 2'd2, 32'h1111_0000 + 32'(k), !(i == 3 || i == 4), 1'b0, 32'h0);
      if (i < 6 && bus.cmd_ready !== 1'b1) lowcnt++;
      if (i == 3 || i == 4) begin
        check("b2b_hold_haddr", bus.HADDR, 32'h4000_0018);
        check("b2b_hold_htrans", 32'(bus.HTRANS), 32'h2);
      end
    end
    check("b2b_ready_low_cycles", 32'(lowcnt), 32'd2);
    check("b2b_rsp_count", 32'(rsp_seen - r0), 32'd4);

    // ERROR on read A with read B pipelined behind it.
    r0 = rsp_seen;
    drive(1'b1, 32'h4000_0020, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'h5555_5555);
    drive(1'b1, 32'h4000_0024, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'h5555_5555);
    drive(1'b0, 32'h0, 1'b0, 2'd2, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
    check("err_c1_ready", 32'(bus.cmd_ready), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 2'd2, 32'h0, 1'b1, 1'b1, 32'h5555_5555);
    check("err_c2_htrans", 32'(bus.HTRANS), 32'h0);
    check("err_c2_ready", 32'(bus.cmd_ready), 32'h0);
    drive(1'b1, 32'h4000_0028, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'h6666_6666);
    check("err_a_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("err_a_rsp_err", 32'(bus.rsp_err), 32'h1);
    check("err_cancel_ready", 32'(bus.cmd_ready), 32'h0);
    drive(1'b1, 32'h4000_0028, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'h6666_6666);
    check("err_b_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("err_b_rsp_err", 32'(bus.rsp_err), 32'h1);
    check("err_b_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("err_b_htrans", 32'(bus.HTRANS), 32'h0);
    check("err_after_ready", 32'(bus.cmd_ready), 32'h1);
    repeat (4) idle(32'h6666_6666);
    check("err_rsp_count", 32'(rsp_seen - r0), 32'd3);

    // Reset while a NONSEQ is on the bus.
    drive(1'b1, 32'h4000_0030, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'h0);
    idle(32'h0);
    check("mid_nonseq", 32'(bus.HTRANS), 32'h2);
    HRESET = 1'b1;
    #1;
    check("mid_rst_htrans", 32'(bus.HTRANS), 32'h0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(negedge HCLK);
    #2 HRESET = 1'b0;
    r0 = rsp_seen;
    repeat (4) idle(32'h0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'h1);
    check("mid_rst_no_rsp", 32'(rsp_seen - r0), 32'd0);

    // Randomized traffic against a randomized slave.
    pending = 0; err_stage = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, wd, rd;
      logic [1:0]  s;
      bit          w, cv, rdy, resp;
      if (pending && !m_took) begin
        cv = 1; a = bus.cmd_addr; w = bus.cmd_write; s = bus.cmd_size; wd = bus.cmd_wdata;
      end else begin
        cv = ($urandom % 100) < 70;
        a  = 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
        w  = $urandom % 2;
        s  = 2'($urandom_range(0, 3));
        wd = $urandom;
      end
      pending = cv;
      rd = $urandom;
      if (err_stage != 0) begin
        rdy = 1; resp = 1; err_stage = 0;
      end else if (dq.size() != 0) begin
        r = $urandom % 100;
        if (r < 8) begin
          rdy = 0; resp = 1; err_stage = 1;
        end else begin
          rdy = (r >= 30); resp = 0;
        end
      end else begin
        rdy  = ($urandom % 100) < 85;
        resp = ($urandom % 100) < 5;
      end
      drive(cv, a, w, s, wd, rdy, resp, rd);
      if (i == 1500) begin
        HRESET = 1'b1;
        @(negedge HCLK);
        #2 HRESET = 1'b0;
        pending = 0; err_stage = 0;
      end
    end
    repeat (10) idle(32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master_port.md
Name: ahb_lite_master_port

Overview:
- Single-initiator AHB-Lite master for the SoC. Converts a simple valid/ready command stream (from a test sequencer, DMA channel or debug bridge) into pipelined AHB-Lite NONSEQ/SINGLE transfers toward slaves such as the GPIO port.
- Returns one registered response per command, carrying read data and error status.
- Supports back-to-back address/data-phase overlap, slave wait states, and the two-cycle ERROR response, including cancellation of the pipelined follow-on transfer.

Parameters:
- AW, 32, HADDR / cmd_addr width.
- HPROT_VAL, 4'b0011, constant driven on HPROT.

Ports:
- HCLK  in  1  bus clock; all logic rising-edge.
- HRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on an edge where cmd_valid&cmd_ready.
- cmd_addr  in  AW  byte address; low bits forced aligned to size.
- cmd_write  in  1  1=write, 0=read.
- cmd_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- cmd_wdata  in  32  write data, right-justified.
- rsp_valid  out  1  one-cycle response pulse; sink always accepts.
- rsp_rdata  out  32  read data, right-justified and zero-extended; 0 for writes.
- rsp_err  out  1  1 = slave ERROR or cancelled.
- HADDR  out  AW  address.
- HTRANS  out  2  only IDLE=2'b00 or NONSEQ=2'b10.
- HWRITE  out  1
- HSIZE  out  3  {1'b0, size}.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  HPROT_VAL.
- HWDATA  out  32  data-phase write data.
- HRDATA  in  32
- HREADY  in  1  transfer-complete from interconnect.
- HRESP  in  1  0=OKAY, 1=ERROR.

Behaviour:
- Two pipeline registers:
  - AP (address phase): ap_valid, addr, write, size, wdata.
  - DP (data phase): dp_valid, write, size, addr[1:0], wdata.
- Bus outputs:
  - HTRANS = ap_valid ? NONSEQ : IDLE.
  - HADDR, HWRITE and HSIZE come from AP, held stable while ap_valid & !HREADY.
- cmd_ready = (!ap_valid | HREADY) & !err_first & !cancel_pend, where err_first = dp_valid & HRESP & !HREADY.
- Edge with HREADY=1:
  - DP <= AP (dp_valid <= ap_valid).
  - AP loads the accepted command, else ap_valid <= 0.
- Edge with HREADY=0 and !ap_valid: AP may load a command (IDLE→NONSEQ during wait is permitted); the loaded address is then held.
- Address alignment: size 1 clears addr[0]; size 2 clears addr[1:0].
- HWDATA (registered from DP) lane replication:
  - byte → {4{wdata[7:0]}}
  - half → {2{wdata[15:0]}}
  - word → wdata
- Response on an edge with dp_valid & HREADY, visible the next cycle:
  - rsp_valid <= 1, rsp_err <= HRESP.
  - Read rsp_rdata: byte = HRDATA >> (8*addr[1:0]) masked to 8 bits; half = HRDATA >> (8*addr[1]*2) masked to 16 bits; word = HRDATA.
  - Write rsp_rdata = 0.
- Error handling (ERROR cycle 1 = HRESP=1 & HREADY=0):
  - If ap_valid on that edge: ap_valid <= 0 (HTRANS=IDLE in cycle 2) and cancel_pend <= 1.
  - Cycle 2 edge (HRESP=1, HREADY=1): errored response issued with rsp_err=1.
  - Following cycle: if cancel_pend, a second pulse is issued with rsp_valid=1, rsp_err=1, rsp_rdata=0, then cancel_pend <= 0.
  - Response order always equals command order.
- Latency: idle, zero-wait slave:
  - Accept at edge E0.
  - NONSEQ in cycle E0..E1.
  - Data phase E1..E2.
  - rsp_valid high E2..E3.
- Throughput: one command per cycle sustained.
- Each slave wait state adds one cycle and stalls cmd_ready while AP is occupied.
- Reset (asynchronous, any time, including mid-transfer):
  - ap_valid = dp_valid = cancel_pend = 0.
  - HTRANS = IDLE, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - cmd_ready = 1 after release.
  - In-flight commands are dropped with no response.
- HRESP=1 while !dp_valid is ignored.

Test Plan:
- Reset mid-transfer: assert HRESET while HTRANS=NONSEQ → same cycle HTRANS=IDLE, rsp_valid=0; after release cmd_ready=1 and no stale response.
- Single word read, zero-wait, HRDATA=32'hDEADBEEF at 0x40000000 → NONSEQ one cycle after accept, HSIZE=2; rsp_valid 3 cycles after accept with rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Byte write 0xA5 to 0x40000003 → HADDR=0x40000003, HSIZE=0, HWDATA=32'hA5A5A5A5 in the data phase; response rsp_err=0, rsp_rdata=0.
- Four back-to-back writes, slave inserts 2 wait states on the second → HADDR/HTRANS held during waits, cmd_ready low for exactly 2 cycles; 4 responses in order, total 7 cycles from first accept to last rsp_valid.
- Half read at 0x...2 with HRDATA=32'h1234ABCD → rsp_rdata=32'h00001234.
- ERROR on read A with read B pipelined → HTRANS=IDLE in ERROR cycle 2; responses A(err=1) then B(err=1, rdata=0) on consecutive cycles; B never completes a bus data phase; cmd_ready low until after B's response.
